memtrace_issue_sched: RTL and testbench

MEMTRACE_ISSUE_SCHED -- requirements
Module: memtrace_issue_sched

---
 rtl/memtrace_pkg.sv | 18 +
 rtl/memtrace_lane_picker.sv | 26 ++
 rtl/memtrace_issue_sched.sv | 161 ++++++++++++++++
 tb/tb_memtrace_issue_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memtrace_pkg.sv
// Shared types and constants for the memory-trace issue scheduler.
package memtrace_pkg;

  localparam int DATA_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A single-lane configuration still needs a 1-bit tid port.
  function automatic int tid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memtrace_lane_picker.sv
// Lowest-set-index selector over the pending lane mask.
module memtrace_lane_picker
  import memtrace_pkg::*;
#(
  parameter int NUM_THREADS = 4
) (
  input  logic [NUM_THREADS-1:0]            mask,
  output logic                              any,
  output logic [tid_width(NUM_THREADS)-1:0] idx
);

  localparam int TW = tid_width(NUM_THREADS);

  assign any = |mask;

  // Scan from the top so the lowest set bit is the one left standing.
  always_comb begin
    idx = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = TW'(i);
      end
    end
  end

endmodule

// File: rtl/memtrace_issue_sched.sv
// Takes per-lane trace vectors, issues one memory request per cycle
// (lowest lane first), bounds outstanding requests and drains at trace end.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready for a trace vector; trace_read_ready=1
//   ST_ISSUE | issuing the latched lanes, lowest index first
//   ST_DRAIN | trace finished, waiting for inflight to reach 0
//   ST_DONE  | terminal until reset; done=1
module memtrace_issue_sched
  import memtrace_pkg::*;
#(
  parameter int NUM_THREADS  = 4,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic                              trace_read_ready,
  input  logic [NUM_THREADS-1:0]            trace_read_valid,
  input  logic [DATA_WIDTH*NUM_THREADS-1:0] trace_read_address,
  input  logic                              trace_read_finished,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [DATA_WIDTH-1:0]             mem_req_address,
  output logic [tid_width(NUM_THREADS)-1:0] mem_req_tid,
  input  logic                              mem_resp_valid,
  output logic                              done,
  output logic                              resp_underflow
);

  localparam int TW = tid_width(NUM_THREADS);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] INFL_MAX = IW'(MAX_INFLIGHT);

  state_e                            state_q, state_d;
  logic [NUM_THREADS-1:0]            pend_q, pend_d;
  logic [DATA_WIDTH*NUM_THREADS-1:0] addr_q;
  logic                              fin_q;
  logic [IW-1:0]                     infl_q, infl_d;
  logic                              uflow_q, uflow_d;

  logic                   pick_any;
  logic [TW-1:0]          pick_idx;
  logic [NUM_THREADS-1:0] pick_onehot;
  logic [NUM_THREADS-1:0] pend_left;
  logic                   capture;
  logic                   fire;

  memtrace_lane_picker #(
    .NUM_THREADS(NUM_THREADS)
  ) u_picker (
    .mask(pend_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign pend_left = pend_q & ~pick_onehot;
  assign capture   = (state_q == ST_IDLE) && (|trace_read_valid);
  assign fire      = mem_req_valid && mem_req_ready;

  always_comb begin
    mem_req_address = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (pick_idx == TW'(i)) begin
        mem_req_address = addr_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_req_tid    = pick_idx;
  assign resp_underflow = uflow_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN looks at the next-cycle count so a final response exits at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|trace_read_valid) begin
          state_d = ST_ISSUE;
        end else if (trace_read_finished) begin
          state_d = ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (fire && (pend_left == '0)) begin
          state_d = fin_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (infl_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trace_read_ready = (state_q == ST_IDLE);
    done             = (state_q == ST_DONE);
    mem_req_valid    = (state_q == ST_ISSUE) && pick_any && (infl_q < INFL_MAX);
  end

  always_comb begin
    pend_d = pend_q;
    if (capture) begin
      pend_d = trace_read_valid;
    end else if (fire) begin
      pend_d = pend_left;
    end
  end

  // Fire and response together cancel out, even at a count of zero.
  always_comb begin
    infl_d  = infl_q;
    uflow_d = uflow_q;
    if (fire && !mem_resp_valid) begin
      infl_d = infl_q + IW'(1);
    end else if (!fire && mem_resp_valid) begin
      if (infl_q == '0) begin
        uflow_d = 1'b1;
      end else begin
        infl_d = infl_q - IW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      addr_q  <= '0;
      fin_q   <= 1'b0;
      infl_q  <= '0;
      uflow_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      infl_q  <= infl_d;
      uflow_q <= uflow_d;
      if (capture) begin
        addr_q <= trace_read_address;
        fin_q  <= trace_read_finished;
      end
    end
  end

endmodule

// File: tb/tb_memtrace_issue_sched.sv
// Directed bench for memtrace_issue_sched; a second instance runs with a
// two-request inflight limit.
module tb_memtrace_issue_sched;
  import memtrace_pkg::*;

  logic         clock;
  logic         reset;
  logic         trace_read_ready;
  logic [3:0]   trace_read_valid;
  logic [255:0] trace_read_address;
  logic         trace_read_finished;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_req_address;
  logic [1:0]   mem_req_tid;
  logic         mem_resp_valid;
  logic         done;
  logic         resp_underflow;

  logic         m2_trace_ready;
  logic [3:0]   m2_valid;
  logic [255:0] m2_addr;
  logic         m2_finished;
  logic         m2_req_valid;
  logic         m2_req_ready;
  logic [63:0]  m2_req_addr;
  logic [1:0]   m2_req_tid;
  logic         m2_resp;
  logic         m2_done;
  logic         m2_uflow;

  int errors = 0;
  int checks = 0;

  memtrace_issue_sched #(
    .NUM_THREADS(4), .DATA_WIDTH(64), .MAX_INFLIGHT(8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .trace_read_ready   (trace_read_ready),
    .trace_read_valid   (trace_read_valid),
    .trace_read_address (trace_read_address),
    .trace_read_finished(trace_read_finished),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_address    (mem_req_address),
    .mem_req_tid        (mem_req_tid),
    .mem_resp_valid     (mem_resp_valid),
    .done               (done),
    .resp_underflow     (resp_underflow)
  );

  memtrace_issue_sched #(
    .NUM_THREADS(4), .DATA_WIDTH(64), .MAX_INFLIGHT(2)
  ) dut2 (
    .clock              (clock),
    .reset              (reset),
    .trace_read_ready   (m2_trace_ready),
    .trace_read_valid   (m2_valid),
    .trace_read_address (m2_addr),
    .trace_read_finished(m2_finished),
    .mem_req_valid      (m2_req_valid),
    .mem_req_ready      (m2_req_ready),
    .mem_req_address    (m2_req_addr),
    .mem_req_tid        (m2_req_tid),
    .mem_resp_valid     (m2_resp),
    .done               (m2_done),
    .resp_underflow     (m2_uflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs;
    trace_read_valid    = '0;
    trace_read_address  = '0;
    trace_read_finished = 1'b0;
    mem_req_ready       = 1'b0;
    mem_resp_valid      = 1'b0;
    m2_valid            = '0;
    m2_addr             = '0;
    m2_finished         = 1'b0;
    m2_req_ready        = 1'b0;
    m2_resp             = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", mem_req_valid); end
    checks++;
    if (trace_read_ready !== 1'b1) begin errors++; $display("FAIL rst_trace_ready: got %b expected 1", trace_read_ready); end
    checks++;
    if (done !== 1'b0 || resp_underflow !== 1'b0) begin errors++; $display("FAIL rst_done_uflow: got %b%b expected 00", done, resp_underflow); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b0 || trace_read_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL post_rst_outputs: got v=%b r=%b d=%b expected v=0 r=1 d=0", mem_req_valid, trace_read_ready, done);
    end
    checks++;
    if (dut.infl_q !== 4'd0 || dut.pend_q !== 4'd0) begin errors++; $display("FAIL post_rst_regs: got infl=%0d pend=%b expected 0/0000", dut.infl_q, dut.pend_q); end
  endtask

  task automatic test_basic;
    do_reset();
    trace_read_address[0*64 +: 64] = 64'h100;
    trace_read_address[1*64 +: 64] = 64'h200;
    trace_read_address[2*64 +: 64] = 64'h300;
    trace_read_address[3*64 +: 64] = 64'h400;
    trace_read_valid = 4'b1011;
    mem_req_ready    = 1'b1;
    @(negedge clock);
    trace_read_valid = '0;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd0 || mem_req_address !== 64'h100) begin
      errors++; $display("FAIL basic_req0: got v=%b tid=%0d addr=%0h expected v=1 tid=0 addr=100", mem_req_valid, mem_req_tid, mem_req_address);
    end
    checks++;
    if (trace_read_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b expected 0", trace_read_ready); end
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd1 || mem_req_address !== 64'h200) begin
      errors++; $display("FAIL basic_req1: got v=%b tid=%0d addr=%0h expected v=1 tid=1 addr=200", mem_req_valid, mem_req_tid, mem_req_address);
    end
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd3 || mem_req_address !== 64'h400) begin
      errors++; $display("FAIL basic_req3: got v=%b tid=%0d addr=%0h expected v=1 tid=3 addr=400", mem_req_valid, mem_req_tid, mem_req_address);
    end
    @(negedge clock);
    checks++;
    if (trace_read_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL basic_back_idle: got r=%b v=%b expected r=1 v=0", trace_read_ready, mem_req_valid);
    end
    checks++;
    if (dut.infl_q !== 4'd3) begin errors++; $display("FAIL basic_inflight: got %0d expected 3", dut.infl_q); end
  endtask

  task automatic test_inflight_limit;
    int fires;
    do_reset();
    for (int g = 0; g < 4; g++) m2_addr[g*64 +: 64] = 64'h1000 + 64'(g) * 64'h10;
    m2_valid     = 4'b1111;
    m2_req_ready = 1'b1;
    fires        = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      m2_valid = '0;
      if (m2_req_valid) fires++;
    end
    checks++;
    if (fires != 2) begin errors++; $display("FAIL limit_fire_count: got %0d expected 2", fires); end
    checks++;
    if (m2_req_valid !== 1'b0) begin errors++; $display("FAIL limit_valid_low: got %b expected 0", m2_req_valid); end
    m2_resp = 1'b1;
    @(negedge clock);
    m2_resp = 1'b0;
    checks++;
    if (m2_req_valid !== 1'b1 || m2_req_tid !== 2'd2 || m2_req_addr !== 64'h1020) begin
      errors++; $display("FAIL limit_resume: got v=%b tid=%0d addr=%0h expected v=1 tid=2 addr=1020", m2_req_valid, m2_req_tid, m2_req_addr);
    end
  endtask

  task automatic test_hold;
    do_reset();
    trace_read_address[2*64 +: 64] = 64'hABC;
    trace_read_valid = 4'b0100;
    mem_req_ready    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      trace_read_valid = '0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tid !== 2'd2 || mem_req_address !== 64'hABC) begin
        errors++; $display("FAIL hold_cycle%0d: got v=%b tid=%0d addr=%0h expected v=1 tid=2 addr=abc", c, mem_req_valid, mem_req_tid, mem_req_address);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_req_valid !== 1'b0 || trace_read_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: got v=%b r=%b expected v=0 r=1", mem_req_valid, trace_read_ready);
    end
  endtask

  task automatic test_drain;
    do_reset();
    trace_read_address[0*64 +: 64] = 64'h55;
    trace_read_valid    = 4'b0001;
    trace_read_finished = 1'b1;
    mem_req_ready       = 1'b1;
    @(negedge clock);
    trace_read_valid    = '0;
    trace_read_finished = 1'b0;
    checks++;
    if (dut.state_q !== ST_ISSUE || mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL drain_issue: got state=%0d v=%b expected state=1 v=1", dut.state_q, mem_req_valid);
    end
    @(negedge clock);
    checks++;
    if (dut.state_q !== ST_DRAIN || trace_read_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL drain_enter: got state=%0d r=%b d=%b expected state=2 r=0 d=0", dut.state_q, trace_read_ready, done);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || dut.state_q !== ST_DRAIN) begin errors++; $display("FAIL drain_wait: got d=%b state=%0d expected d=0 state=2", done, dut.state_q); end
    mem_resp_valid = 1'b1;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || dut.state_q !== ST_DONE || trace_read_ready !== 1'b0) begin
      errors++; $display("FAIL drain_done: got d=%b state=%0d r=%b expected d=1 state=3 r=0", done, dut.state_q, trace_read_ready);
    end
    trace_read_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b1 || trace_read_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL done_terminal%0d: got d=%b r=%b v=%b expected d=1 r=0 v=0", c, done, trace_read_ready, mem_req_valid);
      end
    end
    trace_read_valid = '0;
  endtask

  task automatic test_underflow;
    do_reset();
    mem_resp_valid = 1'b1;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_underflow !== 1'b1 || dut.infl_q !== 4'd0) begin
      errors++; $display("FAIL uflow_set: got u=%b infl=%0d expected u=1 infl=0", resp_underflow, dut.infl_q);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (resp_underflow !== 1'b1) begin errors++; $display("FAIL uflow_sticky: got %b expected 1", resp_underflow); end
    trace_read_address[0*64 +: 64] = 64'h10;
    trace_read_address[1*64 +: 64] = 64'h20;
    trace_read_valid = 4'b0011;
    mem_req_ready    = 1'b1;
    @(negedge clock);
    trace_read_valid = '0;
    @(negedge clock);
    checks++;
    if (dut.infl_q !== 4'd1 || mem_req_tid !== 2'd1 || mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL simul_pre: got infl=%0d tid=%0d v=%b expected infl=1 tid=1 v=1", dut.infl_q, mem_req_tid, mem_req_valid);
    end
    mem_resp_valid = 1'b1;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checks++;
    if (dut.infl_q !== 4'd1 || resp_underflow !== 1'b1) begin
      errors++; $display("FAIL simul_fire_resp: got infl=%0d u=%b expected infl=1 u=1", dut.infl_q, resp_underflow);
    end
  endtask

  task automatic test_reset_mid_issue;
    do_reset();
    for (int g = 0; g < 3; g++) trace_read_address[g*64 +: 64] = 64'h700 + 64'(g);
    trace_read_valid = 4'b0111;
    mem_req_ready    = 1'b1;
    @(negedge clock);
    trace_read_valid = '0;
    @(negedge clock);
    mem_req_ready = 1'b0;
    checks++;
    if (dut.pend_q !== 4'b0110 || mem_req_valid !== 1'b1 || dut.infl_q !== 4'd1) begin
      errors++; $display("FAIL mid_pre: got pend=%b v=%b infl=%0d expected pend=0110 v=1 infl=1", dut.pend_q, mem_req_valid, dut.infl_q);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL mid_async_drop: got v=%b state=%0d expected v=0 state=0", mem_req_valid, dut.state_q);
    end
    checks++;
    if (dut.infl_q !== 4'd0 || dut.pend_q !== 4'd0 || trace_read_ready !== 1'b1) begin
      errors++; $display("FAIL mid_async_clear: got infl=%0d pend=%b r=%b expected 0/0000/1", dut.infl_q, dut.pend_q, trace_read_ready);
    end
    @(negedge clock);
    reset         = 1'b0;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (mem_req_valid !== 1'b0 || dut.state_q !== ST_IDLE) begin
        errors++; $display("FAIL mid_no_stale%0d: got v=%b state=%0d expected v=0 state=0", c, mem_req_valid, dut.state_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inflight_limit();
    test_hold();
    test_drain();
    test_underflow();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
